// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 state encodings, command bytes, parity helper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ps2_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] C_ST_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] C_ST_INHIBIT   = 3'd1;
   localparam logic [STATE_W-1:0] C_ST_SEND      = 3'd2;
   localparam logic [STATE_W-1:0] C_ST_STOP      = 3'd3;
   localparam logic [STATE_W-1:0] C_ST_ACK       = 3'd4;
   localparam logic [STATE_W-1:0] C_ST_WAIT_IDLE = 3'd5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = C_ST_IDLE,
      ST_INHIBIT   = C_ST_INHIBIT,
      ST_SEND      = C_ST_SEND,
      ST_STOP      = C_ST_STOP,
      ST_ACK       = C_ST_ACK,
      ST_WAIT_IDLE = C_ST_WAIT_IDLE
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

   // Parity bit that makes the 9-bit {parity, data} word carry an odd count of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_edge_sync : 2-flop synchronizers for ps2 clock/data, clock fall  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_edge_sync (
   input  logic inclock,
   input  logic resetn,
   input  logic ps2_clock_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic clk_fall,
   output logic dat_s
);

   logic r_clk_meta;
   logic r_clk_sync;
   logic r_clk_prev;
   logic r_dat_meta;
   logic r_dat_sync;

   // Idle bus level is high, so everything resets to 1 to avoid a false fall.
   always_ff @(posedge inclock) begin
      if (!resetn) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= ps2_clock_in;
         r_clk_sync <= r_clk_meta;
         r_clk_prev <= r_clk_sync;
         r_dat_meta <= ps2_data_in;
         r_dat_sync <= r_dat_meta;
      end
   end

   assign clk_s    = r_clk_sync;
   assign clk_fall = r_clk_prev & ~r_clk_sync;
   assign dat_s    = r_dat_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_host_tx : host-to-device PS/2 command byte transmitter           |
// | Optional device-clock timeout enabled by macro PS2_TX_TIMEOUT_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       inclock,
   input  logic       resetn,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   inout  wire        ps2_clock,
   inout  wire        ps2_data
);
   import ps2_pkg::*;

   localparam int CNT_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);

   ps2_tx_state_t    r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic [3:0]       r_bitcnt, w_bitcnt;
   logic [8:0]       r_shift, w_shift;
   logic             r_clk_low, w_clk_low;
   logic             r_dat_low, w_dat_low;
   logic             r_done, w_done;
   logic             r_error, w_error;

   logic             w_clk_s;
   logic             w_fall;
   logic             w_dat_s;

   ps2_edge_sync u_sync (
      .inclock      (inclock),
      .resetn       (resetn),
      .ps2_clock_in (ps2_clock),
      .ps2_data_in  (ps2_data),
      .clk_s        (w_clk_s),
      .clk_fall     (w_fall),
      .dat_s        (w_dat_s)
   );

   // Open-drain: only ever pull low or release.
   assign ps2_clock = r_clk_low ? 1'b0 : 1'bz;
   assign ps2_data  = r_dat_low ? 1'b0 : 1'bz;

   assign tx_busy  = (r_state != ST_IDLE);
   assign tx_done  = r_done;
   assign tx_error = r_error;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] C_TMO = TCNT_W'(TIMEOUT_CYCLES);
   logic [TCNT_W-1:0] r_tcnt, w_tcnt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = TIMEOUT_CYCLES[0];
`endif

   always_ff @(posedge inclock) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_clk_low <= 1'b0;
         r_dat_low <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
         r_tcnt    <= '0;
`endif
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_bitcnt  <= w_bitcnt;
         r_shift   <= w_shift;
         r_clk_low <= w_clk_low;
         r_dat_low <= w_dat_low;
         r_done    <= w_done;
         r_error   <= w_error;
`ifdef PS2_TX_TIMEOUT_EN
         r_tcnt    <= w_tcnt;
`endif
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_bitcnt  = r_bitcnt;
      w_shift   = r_shift;
      w_clk_low = r_clk_low;
      w_dat_low = r_dat_low;
      w_done    = 1'b0;
      w_error   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (tx_start) begin
               w_state   = ST_INHIBIT;
               w_clk_low = 1'b1;
               w_dat_low = 1'b0;
               w_cnt     = '0;
               w_shift   = {odd_parity(tx_data), tx_data};
            end
         end
         ST_INHIBIT: begin
            w_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == C_INH_LAST) begin
               w_dat_low = 1'b1;
               w_clk_low = 1'b0;
               w_bitcnt  = '0;
               w_state   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_fall) begin
               w_dat_low = ~r_shift[r_bitcnt];
               if (r_bitcnt == 4'd8) begin
                  w_state = ST_STOP;
               end else begin
                  w_bitcnt = r_bitcnt + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (w_fall) begin
               w_dat_low = 1'b0;
               w_state   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (w_fall) begin
               w_done  = ~w_dat_s;
               w_error = w_dat_s;
               w_state = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (w_clk_s && w_dat_s) begin
               w_state = ST_IDLE;
            end
         end
         default: begin
            w_state   = ST_IDLE;
            w_clk_low = 1'b0;
            w_dat_low = 1'b0;
         end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog restarts on every device clock fall; idle/inhibit never time out.
      w_tcnt = r_tcnt;
      if (r_state == ST_IDLE || r_state == ST_INHIBIT || w_fall) begin
         w_tcnt = '0;
      end else if (r_tcnt != C_TMO) begin
         w_tcnt = r_tcnt + TCNT_W'(1);
      end
      if (r_tcnt == C_TMO) begin
         if (r_state == ST_SEND || r_state == ST_STOP || r_state == ST_ACK) begin
            w_clk_low = 1'b0;
            w_dat_low = 1'b0;
            w_done    = 1'b0;
            w_error   = 1'b1;
            w_state   = ST_IDLE;
         end else if (r_state == ST_WAIT_IDLE) begin
            w_state = ST_IDLE;
         end
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ps2_host_tx : device-model bench with scoreboard of sent frames   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH      = 5000;
   localparam int TMO      = 400;
   localparam int HALF     = 20;
   localparam int WAIT_MAX = 20000;

   logic       inclock  = 1'b0;
   logic       resetn   = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   wire        ps2_clock;
   wire        ps2_data;

   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   assign ps2_clock = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_data  = dev_dat_low ? 1'b0 : 1'bz;
   pullup (ps2_clock);
   pullup (ps2_data);

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int n_err   = 0;
   int n_both  = 0;
   int n_long  = 0;
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;
   logic [8:0] exp_q[$];

   always #10 inclock = ~inclock;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .inclock   (inclock),
      .resetn    (resetn),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_error  (tx_error),
      .ps2_clock (ps2_clock),
      .ps2_data  (ps2_data)
   );

   always @(negedge inclock) begin
      if (tx_done === 1'b1) n_done++;
      if (tx_error === 1'b1) n_err++;
      if (tx_done === 1'b1 && tx_error === 1'b1) n_both++;
      if ((tx_done === 1'b1 && prev_done === 1'b1) || (tx_error === 1'b1 && prev_err === 1'b1)) n_long++;
      prev_done = tx_done;
      prev_err  = tx_error;
   end

   initial begin
      repeat (90000) @(posedge inclock);
      $display("FAIL watchdog: run exceeded 90000 cycles");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge inclock);
   endtask

   task automatic start_tx(input logic [7:0] d, input logic par);
      @(negedge inclock);
      tx_data  = d;
      tx_start = 1'b1;
      exp_q.push_back({par, d});
      @(negedge inclock);
      tx_start = 1'b0;
      n_tests++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_after_start: tx_busy=%b required 1", tx_busy);
      end
   endtask

   // Device side of one frame: measure inhibit, clock nclk falls, sample on rises.
   task automatic device_frame(input logic ack, input int nclk);
      int t;
      logic [9:0] bits;
      logic [8:0] exp;
      bits = '0;
      t = 0;
      while (ps2_clock !== 1'b0 && t < WAIT_MAX) begin cyc(1); t++; end
      n_tests++;
      if (t >= WAIT_MAX) begin
         n_fail++;
         $display("FAIL inhibit_start: clock not pulled low after %0d cycles", t);
         return;
      end
      t = 0;
      while (ps2_clock === 1'b0 && t < WAIT_MAX) begin cyc(1); t++; end
      n_tests++;
      if (t < INH || t >= WAIT_MAX) begin
         n_fail++;
         $display("FAIL inhibit_len: low for %0d cycles, required >= %0d", t, INH);
      end
      n_tests++;
      if (ps2_data !== 1'b0) begin
         n_fail++;
         $display("FAIL start_bit: data=%b required 0", ps2_data);
      end
      cyc(HALF);
      for (int i = 0; i < nclk; i++) begin
         dev_clk_low = 1'b1;
         cyc(HALF);
         dev_clk_low = 1'b0;
         if (i < 10) bits[i] = ps2_data;
         if (i == 9 && ack) dev_dat_low = 1'b1;
         cyc(HALF);
      end
      dev_dat_low = 1'b0;
      if (nclk == 11) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame: got %h with no frame expected", bits[8:0]);
         end else begin
            exp = exp_q.pop_front();
            if (bits[8:0] !== exp) begin
               n_fail++;
               $display("FAIL frame: got {par,data}=%h required %h", bits[8:0], exp);
            end
         end
         n_tests++;
         if (bits[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_bit: got %b required 1", bits[9]);
         end
      end
   endtask

   task automatic expect_idle(input string name);
      int t = 0;
      while (tx_busy !== 1'b0 && t < 200) begin cyc(1); t++; end
      n_tests++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: tx_busy=%b required 0", name, tx_busy);
      end
   endtask

   task automatic expect_pulses(input string name, input int d0, input int e0, input int dd, input int de);
      n_tests++;
      if ((n_done - d0) !== dd || (n_err - e0) !== de) begin
         n_fail++;
         $display("FAIL %s: done/error pulses %0d/%0d required %0d/%0d", name, n_done - d0, n_err - e0, dd, de);
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      tx_start = 1'b1;
      tx_data  = PS2_CMD_RESET;
      cyc(4);
      n_tests++;
      if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy/done/error=%b%b%b required 000", tx_busy, tx_done, tx_error);
      end
      n_tests++;
      if (ps2_clock !== 1'b1 || ps2_data !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_lines: clock/data=%b%b required 11", ps2_clock, ps2_data);
      end
      tx_start = 1'b0;
      resetn   = 1'b1;
      cyc(3);
      n_tests++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored: tx_busy=%b required 0", tx_busy);
      end
   endtask

   task automatic test_set_led();
      int d0 = n_done, e0 = n_err;
      start_tx(PS2_CMD_SET_LED, 1'b1);
      device_frame(1'b1, 11);
      expect_idle("set_led_idle");
      expect_pulses("set_led_pulses", d0, e0, 1, 0);
   endtask

   task automatic test_parity();
      int d0 = n_done, e0 = n_err;
      start_tx(8'h01, 1'b0);
      device_frame(1'b1, 11);
      expect_idle("parity01_idle");
      start_tx(PS2_CMD_RESET, 1'b1);
      device_frame(1'b1, 11);
      expect_idle("parityFF_idle");
      expect_pulses("parity_pulses", d0, e0, 2, 0);
   endtask

   task automatic test_nack();
      int d0 = n_done, e0 = n_err;
      start_tx(8'h3C, 1'b1);
      device_frame(1'b0, 11);
      expect_idle("nack_idle");
      expect_pulses("nack_pulses", d0, e0, 0, 1);
   endtask

   task automatic test_busy_ignore();
      int d0 = n_done, e0 = n_err;
      start_tx(PS2_CMD_ENABLE, 1'b0);
      fork
         device_frame(1'b1, 11);
         begin
            cyc(INH + 200);
            n_tests++;
            if (tx_busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_in_send: tx_busy=%b required 1", tx_busy);
            end
            tx_data  = 8'h00;
            tx_start = 1'b1;
            cyc(1);
            tx_start = 1'b0;
         end
      join
      expect_idle("busy_ignore_idle");
      cyc(300);
      n_tests++;
      if (tx_busy !== 1'b0 || ps2_clock !== 1'b1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL busy_ignore_no_frame: busy=%b clock=%b queued=%0d required 0,1,0", tx_busy, ps2_clock, exp_q.size());
      end
      expect_pulses("busy_ignore_pulses", d0, e0, 1, 0);
   endtask

   task automatic test_reset_mid_frame();
      int d0 = n_done, e0 = n_err;
      logic [8:0] drop;
      start_tx(8'h0F, 1'b1);
      device_frame(1'b1, 5);
      drop = exp_q.pop_front();
      n_tests++;
      if (ps2_data !== 1'b0) begin
         n_fail++;
         $display("FAIL bit4_driven: data=%b required 0 (bit 4 of %h)", ps2_data, drop[7:0]);
      end
      resetn = 1'b0;
      cyc(1);
      n_tests++;
      if (ps2_clock !== 1'b1 || ps2_data !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_frame: clock/data/busy=%b%b%b required 110", ps2_clock, ps2_data, tx_busy);
      end
      cyc(3);
      resetn = 1'b1;
      cyc(5);
      expect_pulses("reset_mid_pulses", d0, e0, 0, 0);
      d0 = n_done;
      start_tx(PS2_CMD_RESET, 1'b1);
      device_frame(1'b1, 11);
      expect_idle("after_reset_idle");
      expect_pulses("after_reset_pulses", d0, e0, 1, 0);
   endtask

`ifdef PS2_TX_TIMEOUT_EN
   task automatic test_timeout();
      int d0 = n_done, e0 = n_err;
      int t = 0;
      logic [8:0] drop;
      start_tx(8'hA5, 1'b1);
      device_frame(1'b1, 4);
      drop = exp_q.pop_front();
      while (n_err == e0 && t < TMO + 200) begin cyc(1); t++; end
      n_tests++;
      if (n_err == e0 || t < TMO - 3 * HALF) begin
         n_fail++;
         $display("FAIL timeout_error: error after %0d cycles (frame %h), required ~%0d", t, drop, TMO);
      end
      cyc(2);
      n_tests++;
      if (ps2_clock !== 1'b1 || ps2_data !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_release: clock/data/busy=%b%b%b required 110", ps2_clock, ps2_data, tx_busy);
      end
      expect_pulses("timeout_pulses", d0, e0, 0, 1);
   endtask
`endif

   initial begin
      test_reset();
      test_set_led();
      test_parity();
      test_nack();
      test_busy_ignore();
      test_reset_mid_frame();
`ifdef PS2_TX_TIMEOUT_EN
      test_timeout();
`endif
      n_tests++;
      if (n_both != 0 || n_long != 0) begin
         n_fail++;
         $display("FAIL pulse_shape: overlapping=%0d long=%0d required 0/0", n_both, n_long);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
